// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - decoded control word in, datapath and memory strobes out
interface multicycle_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             zero;
   logic             RegWr;
   logic             DataRead;
   logic             DataWrite;
   logic             BrEq;
   logic             BrNeq;
   logic             Jump;
   logic             Jal;
   logic             RegToPc;
   logic             Halt;
   logic             imemREN;
   logic             dmemREN;
   logic             dmemWEN;
   logic             IrEn;
   logic             PcEn;
   logic [1:0]       PcSel;
   logic             RegWEN;
   logic             halt;
   logic             err;
   logic [CNT_W-1:0] instret;

   modport master (
      input  ihit, dhit, zero,
      input  RegWr, DataRead, DataWrite, BrEq, BrNeq, Jump, Jal, RegToPc, Halt,
      output imemREN, dmemREN, dmemWEN, IrEn, PcEn, PcSel, RegWEN,
      output halt, err, instret
   );

   modport slave (
      output ihit, dhit, zero,
      output RegWr, DataRead, DataWrite, BrEq, BrNeq, Jump, Jal, RegToPc, Halt,
      input  imemREN, dmemREN, dmemWEN, IrEn, PcEn, PcSel, RegWEN,
      input  halt, err, instret
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-wait timeout
module multicycle_sequencer #(
   parameter int WAIT_MAX = 255,
   parameter int CNT_W    = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   multicycle_sequencer_if.master ctrl
);

   localparam int             WCW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALTED = 3'd5
   } state_t;

   state_t           state;
   state_t           nextState;
   logic [WCW-1:0]   waitCnt;
   logic             haltQ;
   logic             errQ;
   logic [CNT_W-1:0] instretQ;

   logic             setErr;
   logic             bumpWait;
   logic             retire;
   logic             imemRd;
   logic             dmemRd;
   logic             dmemWr;
   logic             irLoad;
   logic             pcLoad;
   logic [1:0]       pcSel;
   logic             regWrite;
   logic             brTaken;

   assign brTaken = (ctrl.BrEq & ctrl.zero) | (ctrl.BrNeq & ~ctrl.zero);

   always_comb begin
      nextState = state;
      setErr    = 1'b0;
      bumpWait  = 1'b0;
      retire    = 1'b0;
      imemRd    = 1'b0;
      dmemRd    = 1'b0;
      dmemWr    = 1'b0;
      irLoad    = 1'b0;
      pcLoad    = 1'b0;
      pcSel     = 2'd0;
      regWrite  = 1'b0;

      case (state)
         FETCH: begin
            imemRd = 1'b1;
            if (ctrl.ihit) begin
               irLoad    = 1'b1;
               nextState = DECODE;
            end else if (waitCnt == WAIT_LIM) begin
               nextState = HALTED;
               setErr    = 1'b1;
            end else begin
               bumpWait = 1'b1;
            end
         end

         DECODE: begin
            if (ctrl.Halt) begin
               nextState = HALTED;
            end else if (ctrl.DataRead && ctrl.DataWrite) begin
               // load and store together is an illegal decode
               nextState = HALTED;
               setErr    = 1'b1;
            end else begin
               nextState = EXEC;
            end
         end

         EXEC: begin
            nextState = (ctrl.DataRead || ctrl.DataWrite) ? MEM : WB;
         end

         MEM: begin
            dmemRd = ctrl.DataRead;
            dmemWr = ctrl.DataWrite;
            if (ctrl.dhit) begin
               nextState = WB;
            end else if (waitCnt == WAIT_LIM) begin
               nextState = HALTED;
               setErr    = 1'b1;
            end else begin
               bumpWait = 1'b1;
            end
         end

         WB: begin
            pcLoad    = 1'b1;
            regWrite  = ctrl.RegWr | ctrl.Jal;
            retire    = 1'b1;
            nextState = FETCH;
            if (ctrl.RegToPc) begin
               pcSel = 2'd3;
            end else if (ctrl.Jump || ctrl.Jal) begin
               pcSel = 2'd2;
            end else if (brTaken) begin
               pcSel = 2'd1;
            end else begin
               pcSel = 2'd0;
            end
         end

         HALTED: begin
            nextState = HALTED;
         end

         default: begin
            nextState = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= FETCH;
         waitCnt  <= '0;
         haltQ    <= 1'b0;
         errQ     <= 1'b0;
         instretQ <= '0;
      end else begin
         state <= nextState;
         // a fresh state always starts its wait budget from zero
         if (nextState != state) begin
            waitCnt <= '0;
         end else if (bumpWait) begin
            waitCnt <= waitCnt + WCW'(1);
         end
         if (nextState == HALTED) begin
            haltQ <= 1'b1;
         end
         if (setErr) begin
            errQ <= 1'b1;
         end
         if (retire) begin
            instretQ <= instretQ + CNT_W'(1);
         end
      end
   end

   // strobes must not leak out while reset is held, whatever state is registered
   assign ctrl.imemREN = imemRd   & ~RST;
   assign ctrl.dmemREN = dmemRd   & ~RST;
   assign ctrl.dmemWEN = dmemWr   & ~RST;
   assign ctrl.IrEn    = irLoad   & ~RST;
   assign ctrl.PcEn    = pcLoad   & ~RST;
   assign ctrl.RegWEN  = regWrite & ~RST;
   assign ctrl.PcSel   = RST ? 2'd0 : pcSel;
   assign ctrl.halt    = haltQ;
   assign ctrl.err     = errQ;
   assign ctrl.instret = instretQ;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

   logic CLK;
   logic RST;
   int   checks;
   int   failures;
   int   renCnt;
   int   wenCnt;
   int   imemCnt;
   int   irCnt;
   int   anyCnt;

   multicycle_sequencer_if #(.CNT_W(32)) bus ();

   multicycle_sequencer #(.WAIT_MAX(4), .CNT_W(32)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .ctrl (bus.master)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clearDecode();
      bus.RegWr     = 1'b0;
      bus.DataRead  = 1'b0;
      bus.DataWrite = 1'b0;
      bus.BrEq      = 1'b0;
      bus.BrNeq     = 1'b0;
      bus.Jump      = 1'b0;
      bus.Jal       = 1'b0;
      bus.RegToPc   = 1'b0;
      bus.Halt      = 1'b0;
      bus.zero      = 1'b0;
   endtask

   task automatic clearCounts();
      renCnt  = 0;
      wenCnt  = 0;
      imemCnt = 0;
      irCnt   = 0;
      anyCnt  = 0;
   endtask

   // advance to the next negedge, drive hits, then sample the combinational strobes
   task automatic cycle(input logic ih, input logic dh);
      @(negedge CLK);
      bus.ihit = ih;
      bus.dhit = dh;
      #1;
      renCnt  += int'(bus.dmemREN);
      wenCnt  += int'(bus.dmemWEN);
      imemCnt += int'(bus.imemREN);
      irCnt   += int'(bus.IrEn);
      if (bus.imemREN || bus.dmemREN || bus.dmemWEN || bus.IrEn || bus.PcEn || bus.RegWEN)
         anyCnt++;
   endtask

   task automatic doReset();
      @(negedge CLK);
      RST = 1'b1;
      bus.ihit = 1'b0;
      bus.dhit = 1'b0;
      clearDecode();
      @(negedge CLK);
      RST = 1'b0;
      #1;
   endtask

   // from anywhere before FETCH: fetch with hit, DECODE, EXEC, optional MEM, ends sampled in WB
   task automatic execInstr(input int memWaits, input bit useMem);
      cycle(1'b1, 1'b0);
      checkVal("fetch_ir", 32'(bus.IrEn), 32'd1);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      if (useMem) begin
         for (int i = 0; i < memWaits; i++) cycle(1'b0, 1'b0);
         cycle(1'b0, 1'b1);
      end
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      RST      = 1'b1;
      bus.ihit = 1'b0;
      bus.dhit = 1'b0;
      clearDecode();
      clearCounts();

      // reset: strobes forced low while RST is high, state visible after release
      @(negedge CLK);
      #1;
      checkVal("rst_imem_forced", 32'(bus.imemREN), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checkVal("rst_imem", 32'(bus.imemREN), 32'd1);
      checkVal("rst_halt", 32'(bus.halt), 32'd0);
      checkVal("rst_err", 32'(bus.err), 32'd0);
      checkVal("rst_instret", bus.instret, 32'd0);

      // test 1: register op, ihit on 3rd FETCH cycle
      bus.RegWr = 1'b1;
      clearCounts();
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      checkVal("t1_ir_at_hit", 32'(bus.IrEn), 32'd1);
      cycle(1'b0, 1'b0);
      checkVal("t1_decode_imem", 32'(bus.imemREN), 32'd0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      checkVal("t1_wb_pcen", 32'(bus.PcEn), 32'd1);
      checkVal("t1_wb_regwen", 32'(bus.RegWEN), 32'd1);
      checkVal("t1_wb_pcsel", 32'(bus.PcSel), 32'd0);
      cycle(1'b0, 1'b0);
      checkVal("t1_fetch_again", 32'(bus.imemREN), 32'd1);
      checkVal("t1_instret", bus.instret, 32'd1);
      checkVal("t1_ir_pulses", 32'(irCnt), 32'd1);

      // test 2: load with dhit on the 4th MEM cycle
      clearDecode();
      bus.DataRead = 1'b1;
      bus.RegWr    = 1'b1;
      clearCounts();
      execInstr(3, 1'b1);
      checkVal("t2_wb_regwen", 32'(bus.RegWEN), 32'd1);
      checkVal("t2_wb_pcen", 32'(bus.PcEn), 32'd1);
      cycle(1'b0, 1'b0);
      checkVal("t2_ren_cycles", 32'(renCnt), 32'd4);
      checkVal("t2_wen_cycles", 32'(wenCnt), 32'd0);
      checkVal("t2_instret", bus.instret, 32'd2);

      // test 3: next-PC select priority
      clearDecode();
      bus.BrEq = 1'b1;
      bus.zero = 1'b1;
      execInstr(0, 1'b0);
      checkVal("t3_beq_taken", 32'(bus.PcSel), 32'd1);
      checkVal("t3_beq_regwen", 32'(bus.RegWEN), 32'd0);
      bus.zero = 1'b0;
      execInstr(0, 1'b0);
      checkVal("t3_beq_not", 32'(bus.PcSel), 32'd0);
      clearDecode();
      bus.BrNeq = 1'b1;
      execInstr(0, 1'b0);
      checkVal("t3_bne_taken", 32'(bus.PcSel), 32'd1);
      clearDecode();
      bus.RegToPc = 1'b1;
      bus.Jump    = 1'b1;
      execInstr(0, 1'b0);
      checkVal("t3_jr_over_j", 32'(bus.PcSel), 32'd3);
      clearDecode();
      bus.Jal = 1'b1;
      execInstr(0, 1'b0);
      checkVal("t3_jal_sel", 32'(bus.PcSel), 32'd2);
      checkVal("t3_jal_regwen", 32'(bus.RegWEN), 32'd1);
      clearDecode();
      cycle(1'b0, 1'b0);
      checkVal("t3_instret", bus.instret, 32'd7);

      // test 4: Halt decode, then HALTED absorbs hits
      bus.Halt = 1'b1;
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      checkVal("t4_halt_in_decode", 32'(bus.halt), 32'd0);
      cycle(1'b0, 1'b0);
      checkVal("t4_halt", 32'(bus.halt), 32'd1);
      checkVal("t4_err", 32'(bus.err), 32'd0);
      bus.Halt = 1'b0;
      clearCounts();
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
      checkVal("t4_strobes", 32'(anyCnt), 32'd0);
      checkVal("t4_instret", bus.instret, 32'd7);
      checkVal("t4_halt_sticky", 32'(bus.halt), 32'd1);

      // test 5a: FETCH timeout with WAIT_MAX=4
      doReset();
      clearCounts();
      imemCnt = int'(bus.imemREN);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
      checkVal("t5_imem_cycles", 32'(imemCnt), 32'd5);
      checkVal("t5_halt", 32'(bus.halt), 32'd1);
      checkVal("t5_err", 32'(bus.err), 32'd1);

      // test 5b: illegal load+store decode
      doReset();
      bus.DataRead  = 1'b1;
      bus.DataWrite = 1'b1;
      clearCounts();
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      checkVal("t5_illegal_halt", 32'(bus.halt), 32'd1);
      checkVal("t5_illegal_err", 32'(bus.err), 32'd1);
      checkVal("t5_illegal_nomem", 32'(renCnt + wenCnt), 32'd0);

      // test 5c: hit on the last allowed FETCH cycle is accepted
      doReset();
      clearCounts();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      checkVal("t5_edge_ir", 32'(bus.IrEn), 32'd1);
      cycle(1'b0, 1'b0);
      checkVal("t5_edge_decode", 32'(bus.imemREN), 32'd0);
      checkVal("t5_edge_nohalt", 32'(bus.halt), 32'd0);

      // test 5d: MEM timeout on a store
      doReset();
      bus.DataWrite = 1'b1;
      clearCounts();
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
      checkVal("t5_mem_wen_cycles", 32'(wenCnt), 32'd5);
      checkVal("t5_mem_halt", 32'(bus.halt), 32'd1);
      checkVal("t5_mem_err", 32'(bus.err), 32'd1);

      // test 6: reset in the middle of a store
      doReset();
      execInstr(0, 1'b0);
      cycle(1'b0, 1'b0);
      checkVal("t6_pre_instret", bus.instret, 32'd1);
      bus.DataWrite = 1'b1;
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      checkVal("t6_mem_wen", 32'(bus.dmemWEN), 32'd1);
      RST = 1'b1;
      #1;
      checkVal("t6_wen_forced", 32'(bus.dmemWEN), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      bus.DataWrite = 1'b0;
      #1;
      checkVal("t6_fetch", 32'(bus.imemREN), 32'd1);
      checkVal("t6_instret", bus.instret, 32'd0);
      checkVal("t6_halt", 32'(bus.halt), 32'd0);
      checkVal("t6_err", 32'(bus.err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
